mult_div_unit: RTL and testbench

//   Iterative signed multiply/divide unit for the multicycle MIPS datapath, beside the ALU.

---
 rtl/mult_div_if.sv | 25 ++
 rtl/mult_div_unit.sv | 141 ++++++++++++++
 tb/tb_mult_div_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mult_div_if.sv
// Start/operand/result bundle between the multicycle control path and the
// iterative multiply/divide unit.
interface mult_div_if #(
    parameter int unsigned WIDTH = 32
);
    logic             mult_start;
    logic             div_start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output mult_start, div_start, op_a, op_b,
        input  busy, done, div_zero, hi_out, lo_out
    );

    modport slave (
        input  mult_start, div_start, op_a, op_b,
        output busy, done, div_zero, hi_out, lo_out
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) and restoring divide producing HI/LO,
// one iteration per clock, started by a one-cycle pulse.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    mult_div_if.slave  bus
);
    // Booth accumulator {P, multiplier, q-1}; P carries one guard bit so a
    // most-negative multiplicand cannot overflow the add/sub.
    localparam int unsigned AW = 2 * WIDTH + 2;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [AW-1:0]    acc;
    logic [WIDTH:0]   mcand;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic             a_neg;
    logic             q_neg;
    logic             dz;

    logic [WIDTH:0]          p_cur;
    logic [WIDTH:0]          p_sum;
    logic signed [AW-1:0]    booth_pre;
    logic [AW-1:0]           booth_next;
    logic [WIDTH:0]          r_sh;
    logic                    r_ge;
    logic [WIDTH-1:0]        rem_next;
    logic [WIDTH-1:0]        dvd_next;
    logic [WIDTH-1:0]        quo_fix;
    logic [WIDTH-1:0]        rem_fix;
    logic [WIDTH-1:0]        a_mag;
    logic [WIDTH-1:0]        b_mag;

    // One Booth step: add/sub on P, then arithmetic shift of the whole accumulator
    always_comb begin
        p_cur = acc[AW-1:WIDTH+1];
        case (acc[1:0])
            2'b01:   p_sum = p_cur + mcand;
            2'b10:   p_sum = p_cur - mcand;
            default: p_sum = p_cur;
        endcase
        booth_pre  = {p_sum, acc[WIDTH:0]};
        booth_next = booth_pre >>> 1;
    end

    // One restoring-division step; dvd shifts out dividend bits and collects quotient bits
    always_comb begin
        r_sh     = {rem, dvd[WIDTH-1]};
        r_ge     = (r_sh >= {1'b0, dvs});
        rem_next = r_ge ? WIDTH'(r_sh - {1'b0, dvs}) : r_sh[WIDTH-1:0];
        dvd_next = {dvd[WIDTH-2:0], r_ge};
        quo_fix  = q_neg ? -dvd : dvd;
        rem_fix  = a_neg ? -rem : rem;
        a_mag    = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
        b_mag    = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            acc          <= '0;
            mcand        <= '0;
            dvd          <= '0;
            dvs          <= '0;
            rem          <= '0;
            a_neg        <= 1'b0;
            q_neg        <= 1'b0;
            dz           <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
            bus.hi_out   <= '0;
            bus.lo_out   <= '0;
        end else begin
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.mult_start) begin
                        mcand    <= {bus.op_a[WIDTH-1], bus.op_a};
                        acc      <= AW'({bus.op_b, 1'b0});
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= MULT;
                    end else if (bus.div_start) begin
                        dvd      <= a_mag;
                        dvs      <= b_mag;
                        rem      <= '0;
                        a_neg    <= bus.op_a[WIDTH-1];
                        q_neg    <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
                        dz       <= (bus.op_b == '0);
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= DIV;
                    end
                end
                MULT: begin
                    if (cnt == CW'(WIDTH)) begin
                        bus.hi_out <= acc[2*WIDTH:WIDTH+1];
                        bus.lo_out <= acc[WIDTH:1];
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        state      <= FINISH;
                    end else begin
                        acc <= booth_next;
                        cnt <= cnt + CW'(1);
                    end
                end
                DIV: begin
                    // Zero divisor skips the iterations and leaves HI/LO untouched
                    if (dz) begin
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        bus.div_zero <= 1'b1;
                        state        <= FINISH;
                    end else if (cnt == CW'(WIDTH)) begin
                        bus.hi_out <= rem_fix;
                        bus.lo_out <= quo_fix;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        state      <= FINISH;
                    end else begin
                        rem <= rem_next;
                        dvd <= dvd_next;
                        cnt <= cnt + CW'(1);
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed checks of mult_div_unit against a plain-arithmetic
// reference of signed multiply and truncating divide.
module tb_mult_div_unit;
    localparam int unsigned WIDTH = 32;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mult_div_if #(.WIDTH(WIDTH)) bus ();

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0000_0000;
            1:       v = 32'h0000_0001;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h8000_0000;
            4:       v = 32'h7FFF_FFFF;
            5:       v = 32'($urandom_range(0, 200)) - 32'd100;
            default: v = 32'($urandom);
        endcase
        return v;
    endfunction

    // Issue one op and check latency, results and the done/busy/div_zero protocol
    task automatic run_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                          input bit both, input bit disturb);
        longint      sa;
        longint      sb;
        logic [63:0] prod;
        int          exp_lat;
        bit          exp_dz;
        int          lat;
        bit          seen;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        exp_dz = 1'b0;
        exp_lat = 33;
        if (is_mult || both) begin
            prod   = 64'(sa * sb);
            exp_hi = prod[63:32];
            exp_lo = prod[31:0];
        end else if (b == 32'd0) begin
            exp_dz  = 1'b1;
            exp_lat = 1;
        end else begin
            exp_lo = 32'(sa / sb);
            exp_hi = 32'(sa % sb);
        end

        @(negedge clk);
        bus.op_a       = a;
        bus.op_b       = b;
        bus.mult_start = is_mult | both;
        bus.div_start  = ~is_mult | both;
        @(negedge clk);
        bus.mult_start = 1'b0;
        bus.div_start  = 1'b0;
        bus.op_a       = 32'($urandom);
        bus.op_b       = 32'($urandom);
        check("busy_after_accept", 64'(bus.busy), 64'd1);

        lat  = 0;
        seen = 1'b0;
        while (lat < 100 && !seen) begin
            @(negedge clk);
            lat++;
            if (disturb && lat == 5) begin
                bus.div_start = 1'b1;
                bus.op_b      = 32'($urandom);
            end
            if (disturb && lat == 6) bus.div_start = 1'b0;
            seen = bus.done;
        end
        if (!seen) begin
            check("done_timeout", 64'd0, 64'd1);
            return;
        end
        check("latency",  64'(lat),          64'(exp_lat));
        check("hi_out",   64'(bus.hi_out),   64'(exp_hi));
        check("lo_out",   64'(bus.lo_out),   64'(exp_lo));
        check("div_zero", 64'(bus.div_zero), 64'(exp_dz));
        check("busy_in_done", 64'(bus.busy), 64'd0);

        // A start seen during the done cycle must be dropped
        if (disturb) bus.mult_start = 1'b1;
        @(negedge clk);
        bus.mult_start = 1'b0;
        check("done_one_cycle", 64'(bus.done), 64'd0);
        check("idle_not_busy",  64'(bus.busy), 64'd0);
        check("hi_hold", 64'(bus.hi_out), 64'(exp_hi));
        check("lo_hold", 64'(bus.lo_out), 64'(exp_lo));
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        exp_hi         = '0;
        exp_lo         = '0;
        reset          = 1'b1;
        bus.mult_start = 1'b1;
        bus.div_start  = 1'b0;
        bus.op_a       = 32'd3;
        bus.op_b       = 32'd4;
        repeat (3) @(negedge clk);
        check("rst_busy",     64'(bus.busy),     64'd0);
        check("rst_done",     64'(bus.done),     64'd0);
        check("rst_div_zero", 64'(bus.div_zero), 64'd0);
        check("rst_hi",       64'(bus.hi_out),   64'd0);
        check("rst_lo",       64'(bus.lo_out),   64'd0);
        bus.mult_start = 1'b0;
        reset          = 1'b0;
        @(negedge clk);
        check("idle_after_rst", 64'(bus.busy), 64'd0);

        run_op(1'b1, 32'd7,          32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op(1'b1, 32'h8000_0000,  32'h8000_0000, 1'b0, 1'b0);
        run_op(1'b0, 32'hFFFF_FFF9,  32'd2,         1'b0, 1'b0);
        run_op(1'b1, 32'd5,          32'd6,         1'b0, 1'b0);
        run_op(1'b0, 32'd100,        32'd0,         1'b0, 1'b0);
        run_op(1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(1'b0, 32'd7,          32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op(1'b1, 32'd9,          32'd4,         1'b1, 1'b1);
        run_op(1'b0, 32'hFFFF_FF00,  32'd13,        1'b0, 1'b1);

        // Reset in the middle of a divide abandons it
        @(negedge clk);
        bus.op_a      = 32'd1000;
        bus.op_b      = 32'd7;
        bus.div_start = 1'b1;
        @(negedge clk);
        bus.div_start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        check("midrst_busy", 64'(bus.busy),   64'd0);
        check("midrst_done", 64'(bus.done),   64'd0);
        check("midrst_hi",   64'(bus.hi_out), 64'd0);
        check("midrst_lo",   64'(bus.lo_out), 64'd0);
        run_op(1'b1, 32'd2, 32'd3, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            bit          m;
            m  = 1'($urandom_range(0, 1));
            ra = pick_operand();
            rb = pick_operand();
            run_op(m, ra, rb, 1'b0, 1'($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
